// File: rtl/cpu_pkg.sv
// Shared CPU constants: instruction/opcode geometry, PC step and the NOP encoding.
package cpu_pkg;

  localparam int INST_W  = 32;
  localparam int OPC_W   = 11;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 21;
  localparam int PC_STEP = 4;

  localparam logic [INST_W-1:0] NOP = 32'hD503_201F;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INST_W-1:0] inst);
    return inst[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding {pc, inst} entries, with a synchronous flush and an occupancy count.
module fetch_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [W-1:0]                   push_data,
  input  logic                           pop,
  input  logic                           flush,
  output logic [W-1:0]                   head_data,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC, credit-limited imem requests, response buffer and branch redirect.
// Optional FETCH_PERF_CNT_EN adds saturating stall/redirect performance counters.
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter int            AW       = 16,
  parameter int            DEPTH    = 2,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [AW-1:0]     imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [OPC_W-1:0]  inst_opcode,
  output logic [AW-1:0]     inst_pc,
  input  logic              pc_src,
  input  logic [AW-1:0]     redirect_pc,
  input  logic [AW-1:0]     redirect_offset
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_redirect_cnt
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; once
  // raised, req valid/addr hold until accepted (a redirect may withdraw them).
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = CW + 2;

  logic [AW-1:0]        pc;
  logic [AW-1:0]        rsp_pc;
  logic [CW-1:0]        in_flight;
  logic [CW-1:0]        in_flight_next;
  logic [CW-1:0]        drop_cnt;
  logic [CW-1:0]        fifo_count;
  logic [SW-1:0]        credit_sum;
  logic [AW-1:0]        redirect_target;
  logic                 req_acc;
  logic                 rsp_ok;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_empty;
  logic [AW+INST_W-1:0] fifo_head;

  assign credit_sum      = SW'(in_flight) + SW'(fifo_count) + SW'(drop_cnt);
  assign imem_req_valid  = !rst && !pc_src && (credit_sum < SW'(DEPTH));
  assign imem_req_addr   = pc;
  assign req_acc         = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok          = imem_rsp_valid && (in_flight != '0);
  assign fifo_push       = rsp_ok && (drop_cnt == '0) && !pc_src;
  assign fifo_pop        = inst_valid && inst_ready;
  assign in_flight_next  = in_flight + CW'(req_acc) - CW'(rsp_ok);
  assign redirect_target = redirect_pc + (redirect_offset << 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      rsp_pc    <= RESET_PC;
      in_flight <= '0;
      drop_cnt  <= '0;
    end else begin
      in_flight <= in_flight_next;
      if (pc_src) begin
        pc       <= redirect_target;
        rsp_pc   <= redirect_target;
        drop_cnt <= in_flight_next;
      end else begin
        if (req_acc) pc <= pc + AW'(PC_STEP);
        // Responses are in order, so the next kept response belongs to rsp_pc.
        if (fifo_push) rsp_pc <= rsp_pc + AW'(PC_STEP);
        if (rsp_ok && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .W     (AW + INST_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({rsp_pc, imem_rsp_data}),
    .pop       (fifo_pop),
    .flush     (pc_src),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign inst_valid  = !fifo_empty;
  assign inst_data   = inst_valid ? fifo_head[INST_W-1:0] : '0;
  assign inst_pc     = inst_valid ? fifo_head[AW+INST_W-1:INST_W] : '0;
  assign inst_opcode = opcode_of(inst_data);

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt    <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (inst_ready && !inst_valid && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (pc_src && (perf_redirect_cnt != '1))
        perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: in-order memory model plus an expected-PC scoreboard.
module tb_inst_fetch_unit;

  localparam int          AW       = 16;
  localparam int          DEPTH    = 2;
  localparam logic [15:0] RESET_PC = 16'h0040;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [10:0] inst_opcode;
  logic [15:0] inst_pc;
  logic        pc_src = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] redirect_offset = '0;

  inst_fetch_unit #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_opcode     (inst_opcode),
    .inst_pc         (inst_pc),
    .pc_src          (pc_src),
    .redirect_pc     (redirect_pc),
    .redirect_offset (redirect_offset)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  // ---------------- memory model and scoreboard ----------------
  typedef struct {
    logic [15:0] addr;
    int          due;
  } req_t;

  req_t        pend_q[$];
  logic [15:0] exp_q[$];    // addresses accepted and still owed to decode
  logic [15:0] acc_log[$];
  logic [15:0] exp_req_pc = RESET_PC;
  logic [15:0] last_cons_pc = '0;
  int          consumed_cnt = 0;
  int          ready_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return ({16'h0, a} * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  always begin
    logic [15:0] e;
    logic [31:0] ew;
    req_t        r;
    @(negedge clk);
    #1;
    if (rst) begin
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b0;
      pend_q.delete();
      exp_q.delete();
      exp_req_pc = RESET_PC;
    end else begin
      if (inst_valid && inst_ready) begin
        consumed_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_inst: got pc=%h, required no instruction", inst_pc);
        end else begin
          e  = exp_q.pop_front();
          ew = mem_word(e);
          last_cons_pc = inst_pc;
          if (inst_pc !== e) begin
            failures++;
            $display("FAIL inst_pc: got %h, required %h", inst_pc, e);
          end
          checks++;
          if (inst_data !== ew) begin
            failures++;
            $display("FAIL inst_data: got %h, required %h", inst_data, ew);
          end
          checks++;
          if (inst_opcode !== ew[31:21]) begin
            failures++;
            $display("FAIL inst_opcode: got %h, required %h", inst_opcode, ew[31:21]);
          end
        end
      end
      if (pend_q.size() > 0 && pend_q[0].due <= cyc + 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
      imem_req_ready = ($urandom_range(99) < ready_pct);
      if (imem_req_valid && imem_req_ready) begin
        checks++;
        if (imem_req_addr !== exp_req_pc) begin
          failures++;
          $display("FAIL req_addr: got %h, required %h", imem_req_addr, exp_req_pc);
        end
        acc_log.push_back(imem_req_addr);
        exp_q.push_back(imem_req_addr);
        exp_req_pc = exp_req_pc + 16'd4;
        r.addr = imem_req_addr;
        r.due  = cyc + 1 + $urandom_range(lat_max, lat_min);
        pend_q.push_back(r);
      end
      if (pc_src) begin
        checks++;
        if (imem_req_valid !== 1'b0) begin
          failures++;
          $display("FAIL req_during_redirect: got valid=%b, required 0", imem_req_valid);
        end
        exp_q.delete();
        exp_req_pc = redirect_pc + redirect_offset * 16'd4;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_consumed(input int n, input string name);
    int target;
    int budget;
    target = consumed_cnt + n;
    budget = 300;
    while (consumed_cnt < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (consumed_cnt < target) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d consumed, required %0d", name, consumed_cnt, target);
    end
  endtask

  task automatic do_redirect(input logic [15:0] rpc, input logic [15:0] roff);
    @(negedge clk);
    pc_src          = 1'b1;
    redirect_pc     = rpc;
    redirect_offset = roff;
    acc_log.delete();
    @(negedge clk);
    pc_src = 1'b0;
  endtask

  task automatic check_log(input int idx, input logic [15:0] exp, input string name);
    checks++;
    if (acc_log.size() <= idx) begin
      failures++;
      $display("FAIL %s: got %0d accepts, required > %0d", name, acc_log.size(), idx);
    end else if (acc_log[idx] !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, acc_log[idx], exp);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({imem_req_valid, inst_valid, inst_data, inst_pc, inst_opcode} !== '0) begin
      failures++;
      $display("FAIL %s: got req_valid=%b inst_valid=%b data=%h pc=%h opc=%h, required all 0",
               name, imem_req_valid, inst_valid, inst_data, inst_pc, inst_opcode);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #2;
    check_outputs_zero("reset_state");
    @(negedge clk);
    ready_pct = 100; lat_min = 1; lat_max = 1;
    inst_ready = 1'b1;
    acc_log.delete();
    rst = 1'b0;
    wait_consumed(6, "reset");
    check_log(0, 16'h0040, "reset_addr0");
    check_log(1, 16'h0044, "reset_addr1");
    check_log(2, 16'h0048, "reset_addr2");
  endtask

  task automatic test_backpressure;
    int acc_before;
    @(negedge clk);
    inst_ready = 1'b0;
    acc_before = acc_log.size();
    repeat (10) @(negedge clk);
    #3;
    checks++;
    if (acc_log.size() - acc_before > DEPTH) begin
      failures++;
      $display("FAIL bp_accepts: got %0d, required <= %0d", acc_log.size() - acc_before, DEPTH);
    end
    checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_req_valid: got %b, required 0", imem_req_valid);
    end
    checks++;
    if (inst_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_inst_valid: got %b, required 1", inst_valid);
    end
    checks++;
    if (exp_q.size() != DEPTH) begin
      failures++;
      $display("FAIL bp_buffered: got %0d owed, required %0d", exp_q.size(), DEPTH);
    end
    @(negedge clk);
    inst_ready = 1'b1;
    wait_consumed(6, "bp_resume");
  endtask

  task automatic test_redirect;
    int budget;
    lat_min = 3; lat_max = 3;
    budget = 100;
    do begin
      @(negedge clk);
      budget--;
    end while (pend_q.size() != 2 && budget > 0);
    checks++;
    if (pend_q.size() != 2) begin
      failures++;
      $display("FAIL redir_setup: got %0d in flight, required 2", pend_q.size());
    end
    pc_src          = 1'b1;
    redirect_pc     = 16'h0100;
    redirect_offset = 16'hFFFE;
    acc_log.delete();
    @(negedge clk);
    pc_src = 1'b0;
    wait_consumed(1, "redir");
    checks++;
    if (last_cons_pc !== 16'h00F8) begin
      failures++;
      $display("FAIL redir_first_pc: got %h, required 00f8", last_cons_pc);
    end
    check_log(0, 16'h00F8, "redir_addr0");
    wait_consumed(3, "redir_tail");
  endtask

  task automatic test_same_cycle;
    int budget;
    lat_min = 2; lat_max = 2;
    budget = 100;
    do begin
      @(negedge clk);
      budget--;
    end while (!(pend_q.size() > 0 && pend_q[0].due <= cyc + 1) && budget > 0);
    pc_src          = 1'b1;
    redirect_pc     = 16'h0200;
    redirect_offset = 16'h0003;
    acc_log.delete();
    @(negedge clk);
    pc_src = 1'b0;
    #3;
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_no_entry: got inst_valid=%b, required 0", inst_valid);
    end
    wait_consumed(3, "same_cycle");
    check_log(0, 16'h020C, "same_cycle_addr0");
  endtask

  task automatic test_wrap;
    lat_min = 1; lat_max = 1;
    do_redirect(16'hFFF8, 16'h0000);
    wait_consumed(4, "wrap");
    check_log(0, 16'hFFF8, "wrap_addr0");
    check_log(1, 16'hFFFC, "wrap_addr1");
    check_log(2, 16'h0000, "wrap_addr2");
  endtask

  task automatic test_random;
    logic [15:0] off;
    ready_pct = 70; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      inst_ready = ($urandom_range(99) < 75);
      if (!pc_src && $urandom_range(99) < 4) begin
        off             = 16'($urandom_range(64)) - 16'd32;
        pc_src          = 1'b1;
        redirect_pc     = 16'($urandom) & 16'hFFFC;
        redirect_offset = off;
      end else begin
        pc_src = 1'b0;
      end
    end
    @(negedge clk);
    pc_src = 1'b0;
    inst_ready = 1'b1;
    ready_pct = 100;
    wait_consumed(4, "random_drain");
  endtask

  task automatic test_async_reset;
    int budget;
    lat_min = 3; lat_max = 3;
    budget = 100;
    do begin
      @(negedge clk);
      budget--;
    end while (pend_q.size() != 2 && budget > 0);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    acc_log.delete();
    lat_min = 1; lat_max = 1;
    rst = 1'b0;
    wait_consumed(3, "post_reset");
    check_log(0, RESET_PC, "post_reset_addr0");
    check_log(1, RESET_PC + 16'd4, "post_reset_addr1");
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect();
    test_same_cycle();
    test_wrap();
    test_random();
    test_async_reset();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
